axi_sram_satellite: RTL
=======================

Name: axi_sram_satellite

Overview:
- AXI4 satellite (slave) sitting directly downstream of the AXI mux; it attaches to the satellite_to_mux modport of axi_bus_if.
- Backs a single-port, word-wide synchronous SRAM. Services one transaction at a time, either a write burst or a read burst.
- Used for on-chip instruction/data RAM behind the mux.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the SRAM (power of two).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0. Must be aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- axi  interface  axi_bus_if.satellite_to_mux  full AXI4 satellite channel set: AW, W, B, AR, R.
- Unused inputs (lock, cache, prot, qos) are ignored.

Behaviour:
- Reset:
  - rst is synchronous and active-high; one clock; clk and rst as named above.
  - On reset: awready, wready, bvalid, arready, rvalid and rlast = 0; bid, rid, bresp, rresp and rdata = 0; FSM = IDLE.
  - SRAM contents are not reset.
  - Reset asserted mid-burst aborts the burst immediately; no B or remaining R beats are issued.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE:
  - awready = 1 and arready = 1 only in IDLE, and only the selected one is asserted.
  - Write has priority: if awvalid, assert awready only. Else if arvalid, assert arready only.
  - On AW handshake: capture awid, awaddr, awlen, awsize and awburst; go to WDATA.
  - On AR handshake: capture the same AR fields; go to RDATA.
- Burst legality:
  - A burst is legal only if size == 3'b010 and burst is FIXED (00) or INCR (01).
  - An illegal burst is still fully consumed or produced (awlen+1 W beats, or arlen+1 R beats), but performs no SRAM writes. Its read data is 32'h0 and its response is SLVERR (2'b10).
- Addressing:
  - beat address = start for FIXED; start + 4*beat for INCR (32-bit add; no 4 KB boundary check).
  - word index = (addr - BASE_ADDR) >> 2.
  - If addr < BASE_ADDR or index >= DEPTH_WORDS, the beat is DECERR (2'b11): no write, read data 32'h0.
  - Low two address bits are ignored.
- WDATA:
  - wready = 1. Each W handshake writes the bytes selected by wstrb to the SRAM; wstrb = 0 writes nothing.
  - The beat counter counts to awlen+1.
  - wlast must be 1 on exactly the final beat. Any mismatch (early or missing) sets SLVERR, but the block still consumes exactly awlen+1 beats.
  - After the final beat, go to WRESP.
- WRESP:
  - bvalid = 1, bid = captured awid.
  - bresp = highest-priority error seen across the burst: DECERR > SLVERR > OKAY.
  - bvalid and bresp are held until bready; on handshake go to IDLE.
  - The next AW may be accepted no earlier than the cycle after the B handshake.
- RDATA:
  - First rvalid occurs exactly 1 cycle after the AR handshake.
  - rid = captured arid; rresp is per beat; rlast = 1 on beat arlen.
  - rdata, rresp and rlast are held stable while rvalid && !rready.
  - With rready held high, beats are back-to-back, one per cycle (the SRAM read for the next beat is issued on the handshake cycle).
  - After the rlast handshake, go to IDLE; arready is reasserted the following cycle.
- Simultaneous AW and AR in IDLE: AW wins; AR stays pending and is accepted after the write's B handshake.
- W beats arriving before the AW handshake are not accepted (wready = 0 outside WDATA).
- A read-after-write to the same address returns the newly written data.

Test Plan:
- Single write then read:
  - Stimulus: AW addr 0x10, len 0, size 2, INCR, id 3; W 0xDEADBEEF, strb 0xF; then AR 0x10, id 5.
  - Required: bresp OKAY, bid 3; rdata 0xDEADBEEF, rresp OKAY, rid 5, rlast 1, rvalid 1 cycle after AR handshake.
- INCR burst:
  - Stimulus: write len 3 at 0x100, data 1, 2, 3, 4; read len 3 at 0x100 with rready toggling 1, 0, 1, 0.
  - Required: rdata 1, 2, 3, 4 in order, held stable during stalls; rlast only on the 4th beat.
- Byte strobes and FIXED burst:
  - Stimulus: write 0x11223344 to 0x20; then FIXED len 1 to 0x20 with strb 0x1 data 0xAA, then strb 0x8 data 0xBB000000.
  - Required: a read of 0x20 returns 0xBB2233AA.
- Errors:
  - Stimulus: write at BASE_ADDR + DEPTH_WORDS*4; read with size 1; write with wlast early on beat 0 of a len-1 burst.
  - Required: bresp DECERR; rresp SLVERR with rdata 0; bresp SLVERR after 2 W beats consumed.
- Arbitration:
  - Stimulus: awvalid and arvalid asserted in the same cycle.
  - Required: awready first, B completes, then arready; the read returns the post-write data.
- Reset mid-burst:
  - Stimulus: assert rst during beat 2 of a len-7 read.
  - Required: the next cycle has rvalid 0 and state IDLE; a subsequent read works normally.

Source files
------------

// File: rtl/axi_bus_if.sv
// AXI4 bus bundle between the mux and one satellite.
// Data and address are 32 bits wide; only the ID width is configurable.
interface axi_bus_if #(
  parameter int ID_W = 4
);
  // write address
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [3:0]      awqos;
  logic            awvalid;
  logic            awready;
  // write data
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  // write response
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  // read address
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic [3:0]      arqos;
  logic            arvalid;
  logic            arready;
  // read data
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport satellite_to_mux (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport mux_to_satellite (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_sram_satellite.sv
// AXI4 satellite in front of a single-port 32-bit synchronous SRAM.
// One burst at a time; writes win over reads when both are offered in IDLE.
module axi_sram_satellite #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst,
  axi_bus_if.satellite_to_mux axi
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t      state;
  logic [31:0] cur_addr;
  logic [7:0]  len;
  logic [7:0]  cnt;
  logic        fixed;
  logic        legal;
  logic [1:0]  err;

  logic        wready, bvalid, rvalid, rlast, rd_hit_q;
  logic [1:0]  bresp, rresp;
  logic [31:0] mem_q;
  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off[31:2] < 30'(DEPTH_WORDS));
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[AW+1:2];
  endfunction

  function automatic logic burst_ok(input logic [2:0] size, input logic [1:0] burst);
    return (size == 3'b010) && (burst == 2'b00 || burst == 2'b01);
  endfunction

  // Response codes are ordered so that the numerically larger one is the more severe.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Handshakes
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign axi.awready = (state == IDLE) && !rst && axi.awvalid;
  assign axi.arready = (state == IDLE) && !rst && !axi.awvalid && axi.arvalid;
  assign aw_hs = axi.awvalid && axi.awready;
  assign ar_hs = axi.arvalid && axi.arready;
  assign w_hs  = axi.wvalid && wready;
  assign b_hs  = bvalid && axi.bready;
  assign r_hs  = rvalid && axi.rready;

  logic [31:0] nxt_addr;
  assign nxt_addr = fixed ? cur_addr : cur_addr + 32'd4;

  // Write beat
  logic       last_beat, mem_we;
  logic [1:0] w_beat_err, w_err;
  assign last_beat  = (cnt == len);
  assign w_beat_err = !legal ? SLVERR : (!in_range(cur_addr) ? DECERR : OKAY);
  assign w_err      = worst(worst(err, w_beat_err), (axi.wlast != last_beat) ? SLVERR : OKAY);
  assign mem_we     = w_hs && legal && in_range(cur_addr);

  // Read beat: the SRAM fetch for beat N+1 is launched on beat N's handshake.
  logic [31:0] rd_addr;
  logic        rd_legal, rd_hit, rd_load;
  logic [1:0]  rd_resp;
  assign rd_addr  = (state == IDLE) ? axi.araddr : nxt_addr;
  assign rd_legal = (state == IDLE) ? burst_ok(axi.arsize, axi.arburst) : legal;
  assign rd_hit   = rd_legal && in_range(rd_addr);
  assign rd_resp  = !rd_legal ? SLVERR : (!in_range(rd_addr) ? DECERR : OKAY);
  assign rd_load  = ar_hs || (r_hs && !rlast);

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we && axi.wstrb[b]) mem[word_idx(cur_addr)][8*b +: 8] <= axi.wdata[8*b +: 8];
    if (rd_load) mem_q <= mem[word_idx(rd_addr)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      len      <= '0;
      cnt      <= '0;
      fixed    <= 1'b0;
      legal    <= 1'b0;
      err      <= OKAY;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= OKAY;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rresp    <= OKAY;
      rd_hit_q <= 1'b0;
      axi.bid  <= '0;
      axi.rid  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            axi.bid  <= axi.awid;
            cur_addr <= axi.awaddr;
            len      <= axi.awlen;
            fixed    <= (axi.awburst == 2'b00);
            legal    <= burst_ok(axi.awsize, axi.awburst);
            cnt      <= '0;
            err      <= OKAY;
            wready   <= 1'b1;
            state    <= WDATA;
          end else if (ar_hs) begin
            axi.rid  <= axi.arid;
            cur_addr <= axi.araddr;
            len      <= axi.arlen;
            fixed    <= (axi.arburst == 2'b00);
            legal    <= rd_legal;
            cnt      <= '0;
            rvalid   <= 1'b1;
            rlast    <= (axi.arlen == 8'd0);
            rresp    <= rd_resp;
            rd_hit_q <= rd_hit;
            state    <= RDATA;
          end
        end
        WDATA: begin
          if (w_hs) begin
            err      <= w_err;
            cur_addr <= nxt_addr;
            cnt      <= cnt + 8'd1;
            if (last_beat) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bresp  <= w_err;
              state  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (b_hs) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        RDATA: begin
          if (r_hs) begin
            if (rlast) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
              state  <= IDLE;
            end else begin
              cur_addr <= rd_addr;
              cnt      <= cnt + 8'd1;
              rlast    <= (cnt + 8'd1 == len);
              rresp    <= rd_resp;
              rd_hit_q <= rd_hit;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign axi.wready = wready;
  assign axi.bvalid = bvalid;
  assign axi.bresp  = bresp;
  assign axi.rvalid = rvalid;
  assign axi.rlast  = rlast;
  assign axi.rresp  = rresp;
  assign axi.rdata  = rd_hit_q ? mem_q : 32'h0;
endmodule
